cache_arbiter: RTL and testbench

- Shares the single unified cache port between NUM_REQ requesters, e.g. instruction fetch (0) and load/store unit (1).
- Round-robin grant; one request in flight at a time.
- Latches the winner's request and drives it to the cache until the cache signals completion, then returns the data and miss flag to that requester only.
- Aborts with an error on a response timeout, and keeps saturating read-hit/read-miss statistics.

---
 rtl/cache_arbiter_pkg.sv | 15 +
 rtl/cache_arbiter_rr_arbiter.sv | 26 ++
 rtl/cache_arbiter.sv | 121 ++++++++++++
 tb/tb_cache_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// cache_arb_pkg: shared widths, FSM encoding and latched request record for cache_arbiter
package cache_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;
endpackage

// File: rtl/cache_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after the last granted index
// Ports: i_valid (request vector), i_last (last granted index), o_grant (one-hot), o_any (any request)
module rr_arbiter #(
  parameter int N  = 2,
  parameter int LW = 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [LW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic          o_any
);
  logic [LW-1:0] w_j;
  assign o_any = |i_valid;
  // Scan from farthest to nearest so the index right after i_last overwrites any earlier pick.
  always_comb begin
    o_grant = '0;
    w_j = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = LW'((int'(i_last) + k) % N);
      if (i_valid[w_j]) begin
        o_grant = '0;
        o_grant[w_j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one cache port among NUM_REQ requesters with timeout and hit/miss stats
// Ports: rq_* requester side (packed per-requester valid/wr/addr/data in; ready pulse, rdata, miss, err out)
//        c_*  cache side (valid/wr/addr/data out; response, missrate, out in)
//        hit_count/miss_count saturating read statistics
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        rq_valid,
  input  logic [NUM_REQ-1:0]        rq_wr,
  input  logic [ADDR_W*NUM_REQ-1:0] rq_addr,
  input  logic [DATA_W*NUM_REQ-1:0] rq_data,
  output logic [NUM_REQ-1:0]        rq_ready,
  output logic [DATA_W-1:0]         rq_rdata,
  output logic                      rq_miss,
  output logic                      rq_err,
  output logic                      c_valid,
  output logic                      c_wr,
  output logic [ADDR_W-1:0]         c_addr,
  output logic [DATA_W-1:0]         c_data,
  input  logic                      c_response,
  input  logic                      c_missrate,
  input  logic [DATA_W-1:0]         c_out,
  output logic [CNT_W-1:0]          hit_count,
  output logic [CNT_W-1:0]          miss_count
);
  localparam int LW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t             r_state;
  req_t               r_req;
  logic [NUM_REQ-1:0] r_grant;
  logic [LW-1:0]      r_last;
  logic [TW-1:0]      r_cnt;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_miss;
  logic               r_err;
  logic [CNT_W-1:0]   r_hit;
  logic [CNT_W-1:0]   r_mis;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_any;
  logic [LW-1:0]      w_idx;
  req_t               w_sel;
  logic               w_done;
  rr_arbiter #(.N(NUM_REQ), .LW(LW)) u_rr (
    .i_valid (rq_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_any   (w_any)
  );
  always_comb begin
    w_idx = '0;
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_grant[i]) begin
        w_idx = LW'(i);
        w_sel.wr = rq_wr[i];
        w_sel.addr = rq_addr[ADDR_W*i +: ADDR_W];
        w_sel.data = rq_data[DATA_W*i +: DATA_W];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_grant <= '0;
      r_last  <= LW'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_rdata <= '0;
      r_miss  <= 1'b0;
      r_err   <= 1'b0;
      r_hit   <= '0;
      r_mis   <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (w_any) begin
            r_req   <= w_sel;
            r_grant <= w_grant;
            r_last  <= w_idx;
            r_rdata <= '0;
            r_miss  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= ST_ISSUE;
          end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (c_response) begin
            r_rdata <= r_req.wr ? '0 : c_out;
            r_miss  <= !r_req.wr && c_missrate;
            r_state <= ST_DONE;
            if (!r_req.wr && c_missrate && r_mis != '1) r_mis <= r_mis + 1'b1;
            if (!r_req.wr && !c_missrate && r_hit != '1) r_hit <= r_hit + 1'b1;
          end else if (r_cnt == TW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  assign w_done     = r_state == ST_DONE;
  assign c_valid    = r_state == ST_ISSUE || r_state == ST_WAIT;
  assign c_wr       = r_req.wr;
  assign c_addr     = r_req.addr;
  assign c_data     = r_req.data;
  assign rq_ready   = w_done ? r_grant : '0;
  assign rq_rdata   = w_done ? r_rdata : '0;
  assign rq_miss    = w_done && r_miss;
  assign rq_err     = w_done && r_err;
  assign hit_count  = r_hit;
  assign miss_count = r_mis;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed table-driven bench for cache_arbiter (NUM_REQ=2, TIMEOUT=8, CNT_W=4)
module tb_cache_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rq_valid, rq_wr, rq_ready;
  logic [63:0] rq_addr, rq_data;
  logic [31:0] rq_rdata, c_addr, c_data, c_out;
  logic        rq_miss, rq_err, c_valid, c_wr, c_response, c_missrate;
  logic [3:0]  hit_count, miss_count;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [1:0]  valid, wr;
    logic [31:0] addr, data;
    int          dly;
    logic [31:0] cout;
    logic        cmiss, spur;
    int          g;
    logic [31:0] rdata;
    logic        miss, err;
    int          lat;
    logic [3:0]  hit, mis;
  } vec_t;
  vec_t tbl[14];
  cache_arbiter #(.NUM_REQ(2), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_valid(rq_valid), .rq_wr(rq_wr), .rq_addr(rq_addr), .rq_data(rq_data),
    .rq_ready(rq_ready), .rq_rdata(rq_rdata), .rq_miss(rq_miss), .rq_err(rq_err),
    .c_valid(c_valid), .c_wr(c_wr), .c_addr(c_addr), .c_data(c_data),
    .c_response(c_response), .c_missrate(c_missrate), .c_out(c_out),
    .hit_count(hit_count), .miss_count(miss_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [1:0] valid, wr, input logic [31:0] addr, data,
                              input int dly, input logic [31:0] cout, input logic cmiss, spur,
                              input int g, input logic [31:0] rdata, input logic miss, err,
                              input int lat, input logic [3:0] hit, mis);
    vec_t v;
    v.valid = valid; v.wr = wr; v.addr = addr; v.data = data; v.dly = dly; v.cout = cout;
    v.cmiss = cmiss; v.spur = spur; v.g = g; v.rdata = rdata; v.miss = miss; v.err = err;
    v.lat = lat; v.hit = hit; v.mis = mis;
    return v;
  endfunction
  task automatic run_row(input string tag, input vec_t v);
    int  lat;
    bit  seen, done;
    @(negedge clk);
    rq_valid = v.valid;
    rq_wr = v.wr;
    for (int i = 0; i < 2; i++) begin
      rq_addr[32*i +: 32] = (i == v.g) ? v.addr : ~v.addr;
      rq_data[32*i +: 32] = (i == v.g) ? v.data : ~v.data;
    end
    c_response = v.spur;
    c_out = 32'hBAD0BAD0;
    c_missrate = v.spur;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = c_valid;
    end
    check({tag, "_issue_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_c_addr"}, c_addr, v.addr);
    check({tag, "_c_wr"}, 32'(c_wr), 32'(v.wr[v.g]));
    check({tag, "_c_data"}, c_data, v.data);
    rq_addr = '1;
    rq_data = '0;
    rq_wr = ~v.wr;
    lat = 0;
    done = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      c_response = 1'b0;
      c_missrate = 1'b0;
      if (rq_ready != 2'b00) done = 1;
      else if (v.dly >= 0 && lat == v.dly + 1) begin
        c_response = 1'b1;
        c_out = v.cout;
        c_missrate = v.cmiss;
      end
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    if (!done) return;
    check({tag, "_latency"}, 32'(lat), 32'(v.lat));
    check({tag, "_rq_ready"}, 32'(rq_ready), 32'(2'b01 << v.g));
    check({tag, "_rq_rdata"}, rq_rdata, v.rdata);
    check({tag, "_rq_miss"}, 32'(rq_miss), 32'(v.miss));
    check({tag, "_rq_err"}, 32'(rq_err), 32'(v.err));
    check({tag, "_c_valid_low"}, 32'(c_valid), 32'd0);
    check({tag, "_c_addr_held"}, c_addr, v.addr);
    check({tag, "_hit_count"}, 32'(hit_count), 32'(v.hit));
    check({tag, "_miss_count"}, 32'(miss_count), 32'(v.mis));
    rq_valid = 2'b00;
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_rq_ready"}, 32'(rq_ready), 32'd0);
    check({tag, "_rq_rdata"}, rq_rdata, 32'd0);
    check({tag, "_rq_miss"}, 32'(rq_miss), 32'd0);
    check({tag, "_rq_err"}, 32'(rq_err), 32'd0);
    check({tag, "_c_valid"}, 32'(c_valid), 32'd0);
    check({tag, "_c_wr"}, 32'(c_wr), 32'd0);
    check({tag, "_c_addr"}, c_addr, 32'd0);
    check({tag, "_c_data"}, c_data, 32'd0);
    check({tag, "_hit_count"}, 32'(hit_count), 32'd0);
    check({tag, "_miss_count"}, 32'(miss_count), 32'd0);
  endtask
  initial begin
    bit seen;
    vec_t s;
    tbl[0]  = mk(2'b01, 2'b00, 32'h40, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0, 32'hDEADBEEF, 1, 0, 3, 0, 1);
    for (int k = 1; k <= 8; k++)
      tbl[k] = mk(2'b11, 2'b00, 32'h1000 + 32'(k), 32'h0, 0, 32'h1000_0000 + 32'(k), 0,
                  (k == 2 || k == 5), (k % 2), 32'h1000_0000 + 32'(k), 0, 0, 2, 4'(k), 1);
    tbl[9]  = mk(2'b10, 2'b10, 32'h80, 32'h12345678, 0, 32'hFFFFFFFF, 1, 0, 1, 32'h0, 0, 0, 2, 8, 1);
    tbl[10] = mk(2'b01, 2'b00, 32'h90, 32'h0, -1, 32'h0, 0, 0, 0, 32'h0, 0, 1, 9, 8, 1);
    tbl[11] = mk(2'b11, 2'b00, 32'hA0, 32'h0, 2, 32'hCAFEF00D, 0, 0, 1, 32'hCAFEF00D, 0, 0, 4, 9, 1);
    tbl[12] = mk(2'b11, 2'b00, 32'hB0, 32'h0, 0, 32'h55AA55AA, 1, 1, 0, 32'h55AA55AA, 1, 0, 2, 9, 2);
    tbl[13] = mk(2'b01, 2'b01, 32'h200, 32'hA5A5A5A5, 0, 32'h77777777, 1, 0, 0, 32'h0, 0, 0, 2, 9, 2);
    rst_n = 1'b0;
    rq_valid = '0; rq_wr = '0; rq_addr = '0; rq_data = '0;
    c_response = 1'b0; c_missrate = 1'b0; c_out = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    foreach (tbl[i]) run_row($sformatf("row%0d", i), tbl[i]);
    @(negedge clk);
    rq_valid = 2'b10;
    rq_wr = 2'b00;
    rq_addr = {32'h500, 32'h0};
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = c_valid;
    end
    check("midrst_issue_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    check("midrst_in_wait", 32'(c_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    rq_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst_noready%0d", k), 32'(rq_ready), 32'd0);
    end
    rst_n = 1'b1;
    run_row("tie", mk(2'b11, 2'b00, 32'h600, 32'h0, 0, 32'h600D600D, 0, 0, 0, 32'h600D600D, 0, 0, 2, 1, 0));
    for (int k = 0; k < 20; k++) begin
      s = mk(2'b01, 2'b00, 32'h300 + 32'(k), 32'h0, 0, 32'h2000 + 32'(k), 0, 0, 0,
             32'h2000 + 32'(k), 0, 0, 2, (k + 2 > 15) ? 4'd15 : 4'(k + 2), 0);
      run_row($sformatf("sat%0d", k), s);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
